// File: rtl/irq_conditioner_apb.sv
// irq_conditioner_apb: synchronises and polarity-corrects interrupt lines,
// latches them as level or edge pending bits, and exposes control over APB.
module irq_conditioner_apb #(
    parameter int N_IRQ          = 4,
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_IRQ-1:0]          irq_raw_i,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_IRQ-1:0]          irq_o
);

    localparam logic [7:0] A_ENABLE  = 8'h00;
    localparam logic [7:0] A_MODE    = 8'h04;
    localparam logic [7:0] A_POL     = 8'h08;
    localparam logic [7:0] A_PENDING = 8'h0C;
    localparam logic [7:0] A_RAW     = 8'h10;
    localparam logic [7:0] A_SET     = 8'h14;

    logic [N_IRQ-1:0] r_sync1;
    logic [N_IRQ-1:0] r_sync2;
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_enable;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_polarity;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_irq;

    logic [7:0]       w_off;
    logic             w_acc;
    logic             w_sel_en;
    logic             w_sel_mode;
    logic             w_sel_pol;
    logic             w_sel_pend;
    logic             w_sel_raw;
    logic             w_sel_set;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_err;
    logic             w_we;
    logic [N_IRQ-1:0] w_data;
    logic [N_IRQ-1:0] w_asserted;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    assign w_unused_bits = ^{PADDR, PWDATA};

    assign w_off      = PADDR[7:0];
    assign w_acc      = PSEL & PENABLE;
    assign w_sel_en   = (w_off == A_ENABLE);
    assign w_sel_mode = (w_off == A_MODE);
    assign w_sel_pol  = (w_off == A_POL);
    assign w_sel_pend = (w_off == A_PENDING);
    assign w_sel_raw  = (w_off == A_RAW);
    assign w_sel_set  = (w_off == A_SET);

    assign w_rd_ok = w_sel_en | w_sel_mode | w_sel_pol | w_sel_pend | w_sel_raw;
    assign w_wr_ok = w_sel_en | w_sel_mode | w_sel_pol | w_sel_pend | w_sel_set;
    assign w_err   = w_acc & (PWRITE ? ~w_wr_ok : ~w_rd_ok);
    assign w_we    = w_acc & PWRITE & ~w_err;
    assign w_data  = PWDATA[N_IRQ-1:0];

    assign w_asserted = r_sync2 ^ r_polarity;
    assign w_rise     = w_asserted & ~r_prev;
    assign w_set      = {N_IRQ{w_we & w_sel_set}} & w_data;
    assign w_clr      = {N_IRQ{w_we & w_sel_pend}} & w_data;

    // Edge bits: set beats a same-cycle clear. Level bits track the line.
    assign w_pend_nxt = (r_mode & (w_rise | w_set | (r_pending & ~w_clr)))
                      | (~r_mode & w_asserted);

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_en:   w_rdata = 32'(r_enable);
            w_sel_mode: w_rdata = 32'(r_mode);
            w_sel_pol:  w_rdata = 32'(r_polarity);
            w_sel_pend: w_rdata = 32'(r_pending);
            w_sel_raw:  w_rdata = 32'(w_asserted);
            default:    w_rdata = '0;
        endcase
    end

    // Response is gated by reset so nothing leaks while aresetn is low.
    assign PREADY  = 1'b1;
    assign PSLVERR = aresetn & w_err;
    assign PRDATA  = (aresetn & w_acc & ~PWRITE & ~w_err) ? w_rdata : '0;
    assign irq_o   = r_irq;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_enable   <= '0;
            r_mode     <= '0;
            r_polarity <= '0;
            r_pending  <= '0;
            r_irq      <= '0;
        end else begin
            r_sync1   <= irq_raw_i;
            r_sync2   <= r_sync1;
            r_prev    <= w_asserted;
            r_pending <= w_pend_nxt;
            r_irq     <= r_pending & r_enable;
            if (w_we && w_sel_en)   r_enable   <= w_data;
            if (w_we && w_sel_mode) r_mode     <= w_data;
            if (w_we && w_sel_pol)  r_polarity <= w_data;
        end
    end

endmodule

// File: tb/tb_irq_conditioner_apb.sv
// Bench for irq_conditioner_apb: register table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_irq_conditioner_apb;

    localparam int N = 4;

    logic          aclk      = 1'b0;
    logic          aresetn   = 1'b0;
    logic [N-1:0]  irq_raw_i = '0;
    logic          PSEL      = 1'b0;
    logic          PENABLE   = 1'b0;
    logic          PWRITE    = 1'b0;
    logic [31:0]   PADDR     = '0;
    logic [31:0]   PWDATA    = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [N-1:0]  irq_o;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_irq = 1'b0;

    always #5 aclk = ~aclk;

    irq_conditioner_apb #(.N_IRQ(N), .APB_ADDR_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .irq_raw_i(irq_raw_i),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq_o)
    );

    // Reference model: raw history queue, asserted = line two samples ago ^ pol
    logic [N-1:0] m_en = '0, m_mode = '0, m_pol = '0;
    logic [N-1:0] m_pend = '0, m_irq = '0, m_last = '0;
    logic [N-1:0] raw_q[$] = '{4'h0, 4'h0};

    function automatic logic [32:0] mexp(input bit wr, input logic [7:0] off);
        logic [N-1:0] a;
        a = raw_q[raw_q.size()-2] ^ m_pol;
        if (wr)
            return {!(off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h14}), 32'h0};
        case (off)
            8'h00:   return {1'b0, 28'h0, m_en};
            8'h04:   return {1'b0, 28'h0, m_mode};
            8'h08:   return {1'b0, 28'h0, m_pol};
            8'h0C:   return {1'b0, 28'h0, m_pend};
            8'h10:   return {1'b0, 28'h0, a};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        logic [N-1:0] a, rise, setb, clrb, n_en, n_mode, n_pol;
        logic [32:0]  e;
        if (!aresetn) begin
            m_en = '0; m_mode = '0; m_pol = '0;
            m_pend = '0; m_irq = '0; m_last = '0;
            raw_q = '{4'h0, 4'h0};
        end else begin
            a = raw_q[raw_q.size()-2] ^ m_pol;
            rise = a & ~m_last;
            m_last = a;
            raw_q.push_back(irq_raw_i);
            if (raw_q.size() > 4) void'(raw_q.pop_front());
            setb = '0; clrb = '0;
            n_en = m_en; n_mode = m_mode; n_pol = m_pol;
            m_irq = m_pend & m_en;
            if (PSEL && PENABLE) begin
                e = mexp(PWRITE, PADDR[7:0]);
                if (PWRITE && !e[32]) begin
                    case (PADDR[7:0])
                        8'h00: n_en = PWDATA[N-1:0];
                        8'h04: n_mode = PWDATA[N-1:0];
                        8'h08: n_pol = PWDATA[N-1:0];
                        8'h0C: clrb = PWDATA[N-1:0];
                        8'h14: setb = PWDATA[N-1:0];
                        default: ;
                    endcase
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) begin
                    if (rise[i] || setb[i]) m_pend[i] = 1'b1;
                    else if (clrb[i]) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = a[i];
                end
            end
            m_en = n_en; m_mode = n_mode; m_pol = n_pol;
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (chk_irq) check("irq_model", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic apb(input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output logic [32:0] exp);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wd;
        tick();
        PENABLE = 1'b1;
        #1;
        rd = PRDATA; err = PSLVERR;
        exp = mexp(wr, addr[7:0]);
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] rd; logic err; logic [32:0] e;
        apb(1'b1, {24'h0, off}, d, rd, err, e);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] off,
                          input logic [31:0] exp_d);
        logic [31:0] rd; logic err; logic [32:0] e;
        apb(1'b0, {24'h0, off}, 32'h0, rd, err, e);
        check(nm, rd, exp_d);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; irq_raw_i = '0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eerr;
    } vec_t;

    vec_t tbl[13];
    logic [7:0] offs[8] = '{8'h00, 8'h04, 8'h08, 8'h0C,
                            8'h10, 8'h14, 8'h18, 8'h02};

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [32:0] e;

        tbl[0]  = '{"w_enable_wide", 1, 8'h00, 32'hFFFF_FFFF, 32'h0, 0};
        tbl[1]  = '{"r_enable",      0, 8'h00, 32'h0, 32'hF, 0};
        tbl[2]  = '{"w_mode",        1, 8'h04, 32'h5, 32'h0, 0};
        tbl[3]  = '{"r_mode",        0, 8'h04, 32'h0, 32'h5, 0};
        tbl[4]  = '{"r_polarity",    0, 8'h08, 32'h0, 32'h0, 0};
        tbl[5]  = '{"r_pending",     0, 8'h0C, 32'h0, 32'h0, 0};
        tbl[6]  = '{"r_raw",         0, 8'h10, 32'h0, 32'h0, 0};
        tbl[7]  = '{"r_unmapped",    0, 8'h18, 32'h0, 32'h0, 1};
        tbl[8]  = '{"w_raw",         1, 8'h10, 32'h3, 32'h0, 1};
        tbl[9]  = '{"r_set",         0, 8'h14, 32'h0, 32'h0, 1};
        tbl[10] = '{"w_unmapped",    1, 8'h1C, 32'hF, 32'h0, 1};
        tbl[11] = '{"r_unaligned",   0, 8'h02, 32'h0, 32'h0, 1};
        tbl[12] = '{"r_raw_after",   0, 8'h10, 32'h0, 32'h0, 0};

        // Reset state, with an unmapped access held on the bus
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h18;
        #2;
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        do_reset();

        foreach (tbl[i]) begin
            apb(tbl[i].wr, {24'hA5A5A5, tbl[i].off}, tbl[i].wd, rd, err, e);
            check({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].eerr));
            if (!tbl[i].wr) check({tbl[i].name, "_data"}, rd, tbl[i].erd);
        end

        // Level path latency
        do_reset();
        wr(8'h00, 32'hF);
        irq_raw_i = 4'h1;
        tick(); tick(); tick();
        check("lvl_edge3", 32'(irq_o), 32'h0);
        tick();
        check("lvl_edge4", 32'(irq_o), 32'h1);
        irq_raw_i = 4'h0;
        tick(); tick(); tick();
        check("lvl_drop3", 32'(irq_o), 32'h1);
        tick();
        check("lvl_drop4", 32'(irq_o), 32'h0);

        // Edge latch and W1C
        do_reset();
        wr(8'h04, 32'h2);
        wr(8'h00, 32'h2);
        irq_raw_i = 4'h2;
        tick(); tick(); tick();
        irq_raw_i = 4'h0;
        repeat (6) tick();
        check("edge_held", 32'(irq_o), 32'h2);
        wr(8'h0C, 32'h2);
        check("w1c_same_edge", 32'(irq_o), 32'h2);
        tick();
        check("w1c_next_edge", 32'(irq_o), 32'h0);

        // Rise and W1C land on the same edge
        repeat (3) tick();
        irq_raw_i = 4'h2;
        tick();
        wr(8'h0C, 32'h2);
        rd_chk("collision_pend", 8'h0C, 32'h2);
        check("collision_irq", 32'(irq_o), 32'h2);

        // Polarity
        do_reset();
        wr(8'h08, 32'h4);
        irq_raw_i = 4'h4;
        repeat (3) tick();
        rd_chk("pol_raw_hi", 8'h10, 32'h0);
        irq_raw_i = 4'h0;
        repeat (3) tick();
        rd_chk("pol_raw_lo", 8'h10, 32'h4);
        rd_chk("pol_pending", 8'h0C, 32'h4);
        check("pol_irq_dis", 32'(irq_o), 32'h0);

        // Errors and SET
        do_reset();
        wr(8'h10, 32'hF);
        rd_chk("raw_unchanged", 8'h10, 32'h0);
        wr(8'h04, 32'h8);
        wr(8'h14, 32'h8);
        rd_chk("set_edge", 8'h0C, 32'h8);
        wr(8'h14, 32'h1);
        rd_chk("set_level_ignored", 8'h0C, 32'h8);

        // Reset in the middle of an access
        do_reset();
        wr(8'h04, 32'hF);
        wr(8'h00, 32'hF);
        wr(8'h14, 32'hF);
        tick();
        check("pre_rst_irq", 32'(irq_o), 32'hF);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h18;
        tick();
        PENABLE = 1'b1;
        aresetn = 1'b0;
        #1;
        check("midrst_irq", 32'(irq_o), 32'h0);
        check("midrst_pslverr", 32'(PSLVERR), 32'h0);
        check("midrst_prdata", PRDATA, 32'h0);
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        aresetn = 1'b1;
        chk_irq = 1'b1;
        repeat (6) tick();
        check("post_rst_irq", 32'(irq_o), 32'h0);
        rd_chk("post_rst_pend", 8'h0C, 32'h0);
        rd_chk("post_rst_en", 8'h00, 32'h0);

        // Randomized run against the model
        for (int it = 0; it < 600; it++) begin
            int r;
            int k;
            bit w;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                if ($urandom_range(0, 2) == 0) irq_raw_i = N'($urandom);
                tick();
            end else begin
                k = $urandom_range(0, 7);
                w = 1'($urandom_range(0, 1));
                apb(w, ($urandom & 32'hFFFF_FF00) | 32'(offs[k]),
                    $urandom, rd, err, e);
                check("rnd_err", 32'(err), 32'(e[32]));
                if (!w) check("rnd_rdata", rd, e[31:0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_conditioner_apb.md
IRQ_CONDITIONER_APB -- requirements
Module: irq_conditioner_apb

Interface
REQ-001 SHALL have parameter N_IRQ, default 4, the number of interrupt lines conditioned, legal range 1..32.
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 32, the APB address width.
REQ-003 SHALL have input aclk, 1 bit, the single clock; all state is on its rising edge.
REQ-004 SHALL have input aresetn, 1 bit; reset is asynchronous assert, active-low.
REQ-005 SHALL have input irq_raw_i, N_IRQ bits, asynchronous external interrupt lines.
REQ-006 SHALL have inputs PSEL (1 bit), PENABLE (1 bit), PWRITE (1 bit), PADDR (APB_ADDR_WIDTH bits) and PWDATA (32 bits), forming the APB slave request.
REQ-007 SHALL have outputs PRDATA (32 bits), PREADY (1 bit) and PSLVERR (1 bit), forming the APB slave response.
REQ-008 SHALL have output irq_o, N_IRQ bits: conditioned level interrupts to the PLIC irq_sources inputs, which run with le_i=0.

Function
REQ-009 SHALL synchronise each irq_raw_i bit through two flops (sync1, sync2), reset 0.
REQ-010 SHALL form asserted[i] = sync2[i] XOR POLARITY[i], where POLARITY bit 1 means active-low.
REQ-011 SHALL keep register prev[i], reset 0, loaded with asserted[i] every cycle; rise[i] = asserted[i] AND NOT prev[i].
REQ-012 SHALL decode the register map from PADDR[7:0], word-aligned:
  - 0x00 ENABLE, RW, reset 0
  - 0x04 MODE, RW, reset 0 (1 = edge, 0 = level)
  - 0x08 POLARITY, RW, reset 0
  - 0x0C PENDING, W1C
  - 0x10 RAW, RO, returns asserted
  - 0x14 SET, WO, W1S into PENDING
REQ-013 SHALL drive PREADY constant 1 (zero wait states); an access completes when PSEL and PENABLE are both 1.
REQ-014 SHALL drive PSLVERR=1, PRDATA=0 and no state change for an unmapped offset, a write to RAW, or a read of SET; otherwise PSLVERR=0.
REQ-015 SHALL drive PRDATA combinationally during the access phase; bits N_IRQ..31 read 0, and those bits are ignored on writes.
REQ-016 SHALL, for edge mode (MODE[i]=1), set PENDING[i] on rise[i] or a SET write with bit i=1; clear it on a PENDING write with bit i=1; set wins over a same-cycle clear.
REQ-017 SHALL, for level mode (MODE[i]=0), load PENDING[i] with asserted[i] each cycle; W1C and SET have no effect.
REQ-018 SHALL capture PENDING regardless of ENABLE.
REQ-019 SHALL register irq_o[i] as PENDING[i] AND ENABLE[i], reset 0.
REQ-020 SHALL give latency from an irq_raw_i edge to irq_o of 4 aclk edges in edge mode and 4 in level mode (sync1, sync2, PENDING, irq_o).
REQ-021 SHALL have a register write take effect on the clock edge that ends the access phase; the irq_o effect appears one edge later.
REQ-022 SHALL treat a POLARITY or MODE write that makes asserted rise as a rise, setting PENDING when in edge mode.
REQ-023 SHALL, when MODE[i] switches from level to edge, retain the current PENDING[i] value.
REQ-024 SHALL have PENDING keep 1 in edge mode on repeated rises until cleared; no counting.

Reset
REQ-025 SHALL, on aresetn low, asynchronously clear sync1, sync2, prev, ENABLE, MODE, POLARITY, PENDING and irq_o.
REQ-026 SHALL hold PRDATA=0, PSLVERR=0 and PREADY=1 while aresetn is low.
REQ-027 SHALL ignore APB accesses during reset; a reset mid-access aborts it with no register update.
REQ-028 SHALL deassert reset synchronously to aclk; the first post-reset edge produces no spurious rise because prev and asserted are both 0.

Verification
REQ-029 Level: N_IRQ=4, write ENABLE=0xF; drive irq_raw_i=0x1 -> irq_o=0x1 on the 4th edge; drop input -> irq_o=0 four edges later.
REQ-030 Edge + W1C: MODE=0x2, ENABLE=0x2; pulse irq_raw_i[1] for 3 cycles -> irq_o[1] stays 1; write PENDING=0x2 -> irq_o[1]=0 one edge later.
REQ-031 Collision: W1C of bit 1 in the same cycle as rise[1] -> PENDING[1] stays 1.
REQ-032 Polarity: POLARITY=0x4, input bit2=1 -> RAW reads 0x0; input bit2=0 -> RAW=0x4; ENABLE=0 -> PENDING=0x4 and irq_o=0.
REQ-033 Errors: read 0x18 -> PSLVERR=1, PRDATA=0; write RAW -> PSLVERR=1 and RAW is unchanged; SET=0x8 with MODE=0x8 -> PENDING[3]=1.
REQ-034 Reset mid-operation: PENDING=0xF, assert aresetn -> all outputs 0 immediately; after release, inputs held at 0 -> irq_o remains 0.
